sram_arbiter: RTL and testbench

Single-port SRAM arbiter for the Huffman compressor. It shares the scratch SRAM among three requesters: tree builder (0), code transform (1) and output encoder (2). One requester owns the memory at a time, and the grant is held for as long as that requester keeps its request high. Commands from the owner are registered onto the SRAM port. Read data is returned with a per-requester valid strobe, and in-flight reads are drained before ownership changes.

---
 rtl/sram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Scratch SRAM arbiter for the Huffman compressor: three requesters, registered SRAM port, read drain on handoff.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module sram_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            req_r,
  input  logic [2:0]            req_w,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            grant,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [2:0]            rvalid,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT);

  state_t              state_r;
  logic [1:0]          owner_r;
  logic [2:0]          cnt_r;
  logic [2:0]          grant_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_r_r;
  logic                mem_w_r;
  logic                err_r;
  logic [2:0]          pipe_r [MEM_LAT];

  logic [1:0]          win_s;
  logic [ADDR_W-1:0]   own_addr_s;
  logic [DATA_W-1:0]   own_wdata_s;
  logic                own_req_s;
  logic                own_rd_s;
  logic                own_wr_s;

`ifdef ARB_RR_EN
  logic [1:0] ptr_r;
  logic [1:0] cand1_s;
  logic [1:0] cand2_s;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    case (v)
      2'd0:    inc3 = 2'd1;
      2'd1:    inc3 = 2'd2;
      default: inc3 = 2'd0;
    endcase
  endfunction

  // Winner search starting at the rotating pointer
  always_comb begin
    cand1_s = inc3(ptr_r);
    cand2_s = inc3(cand1_s);
    if (req[ptr_r]) begin
      win_s = ptr_r;
    end else if (req[cand1_s]) begin
      win_s = cand1_s;
    end else if (req[cand2_s]) begin
      win_s = cand2_s;
    end else begin
      win_s = 2'd0;
    end
  end

  // Pointer moves past each new winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (state_r == IDLE && (|req)) begin
      ptr_r <= inc3(win_s);
    end
  end
`else
  // Fixed priority winner, requester 0 highest
  always_comb begin
    if (req[0]) begin
      win_s = 2'd0;
    end else if (req[1]) begin
      win_s = 2'd1;
    end else if (req[2]) begin
      win_s = 2'd2;
    end else begin
      win_s = 2'd0;
    end
  end
`endif

  // Select the current owner's request, commands and slices
  always_comb begin
    own_addr_s  = req_addr[ADDR_W-1:0];
    own_wdata_s = req_wdata[DATA_W-1:0];
    own_req_s   = req[0];
    own_rd_s    = req_r[0];
    own_wr_s    = req_w[0];
    case (owner_r)
      2'd1: begin
        own_addr_s  = req_addr[ADDR_W +: ADDR_W];
        own_wdata_s = req_wdata[DATA_W +: DATA_W];
        own_req_s   = req[1];
        own_rd_s    = req_r[1];
        own_wr_s    = req_w[1];
      end
      2'd2: begin
        own_addr_s  = req_addr[2*ADDR_W +: ADDR_W];
        own_wdata_s = req_wdata[2*DATA_W +: DATA_W];
        own_req_s   = req[2];
        own_rd_s    = req_r[2];
        own_wr_s    = req_w[2];
      end
      default: begin
        own_addr_s  = req_addr[ADDR_W-1:0];
        own_wdata_s = req_wdata[DATA_W-1:0];
        own_req_s   = req[0];
        own_rd_s    = req_r[0];
        own_wr_s    = req_w[0];
      end
    endcase
  end

  // Ownership FSM with registered SRAM command port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 2'd0;
      cnt_r       <= 3'd0;
      grant_r     <= 3'b000;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_r_r     <= 1'b0;
      mem_w_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_r_r <= 1'b0;
          mem_w_r <= 1'b0;
          if (|req) begin
            grant_r <= 3'b001 << win_s;
            owner_r <= win_s;
            state_r <= OWN;
          end
        end
        OWN: begin
          if (own_req_s) begin
            mem_addr_r  <= own_addr_s;
            mem_wdata_r <= own_wdata_s;
            mem_w_r     <= own_wr_s;
            // A simultaneous read and write keeps the write and flags the conflict
            mem_r_r     <= own_rd_s & ~own_wr_s;
            if (own_rd_s && own_wr_s) begin
              err_r <= 1'b1;
            end
          end else begin
            grant_r <= 3'b000;
            mem_r_r <= 1'b0;
            mem_w_r <= 1'b0;
            cnt_r   <= CNT_INIT;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r <= 3'd1) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 3'b000;
          mem_r_r <= 1'b0;
          mem_w_r <= 1'b0;
        end
      endcase
    end
  end

  // Owner-tagged read return pipe, MEM_LAT stages deep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < MEM_LAT; j++) begin
        pipe_r[j] <= 3'b000;
      end
    end else begin
      pipe_r[0] <= {3{mem_r_r}} & grant_r;
      for (int j = 1; j < MEM_LAT; j++) begin
        pipe_r[j] <= pipe_r[j-1];
      end
    end
  end

  assign grant     = grant_r;
  assign mem_addr  = mem_addr_r;
  assign mem_r     = mem_r_r;
  assign mem_w     = mem_w_r;
  assign mem_wdata = mem_wdata_r;
  assign err       = err_r;
  assign rvalid    = pipe_r[MEM_LAT-1];
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed test-plan sequences plus random traffic against a cycle-timeline reference model.
module tb_sram_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int MAXC = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req, req_r, req_w;
  logic [3*AW-1:0]   req_addr;
  logic [3*DW-1:0]   req_wdata;
  logic [2:0]        grant;
  logic [AW-1:0]     mem_addr;
  logic              mem_r, mem_w;
  logic [DW-1:0]     mem_wdata, mem_rdata, rdata;
  logic [2:0]        rvalid;
  logic              err;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_r(req_r), .req_w(req_w),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
    .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  // Environment SRAM (driven by the DUT bus) and the model's own view of memory
  logic [DW-1:0] sram   [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] rsched [0:MAXC-1];
  logic [2:0]    exp_rv [0:MAXC-1];
  logic [DW-1:0] exp_rd [0:MAXC-1];

  int cyc, m_owner, m_free, m_ptr;
  int n_checks, n_pass;
  logic [2:0]    e_grant;
  logic          e_r, e_w, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          s_r, s_w;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd;
  logic [2:0]    order [0:2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    for (int o = 0; o < 3; o++) begin
      if (r[(p + o) % 3]) return (p + o) % 3;
    end
    return 0;
  endfunction

  task automatic model_reset();
    cyc = 0; m_owner = -1; m_free = 0; m_ptr = 0;
    e_grant = 3'b000; e_r = 1'b0; e_w = 1'b0; e_err = 1'b0;
    e_addr = '0; e_wd = '0;
    s_r = 1'b0; s_w = 1'b0; s_addr = '0; s_wd = '0;
    mem_rdata = '0;
    for (int k = 0; k < MAXC; k++) begin
      exp_rv[k] = 3'b000; rsched[k] = '0;
    end
  endtask

  // Advance one clock: environment SRAM reacts, reference model computes the next cycle's outputs
  task automatic model_step();
    int i, w;
    if (s_w) sram[s_addr] = s_wd;
    if (s_r) rsched[cyc + LAT] = sram[s_addr];
    e_r = 1'b0; e_w = 1'b0;
    if (m_owner < 0) begin
      if (cyc >= m_free && req != 3'b000) begin
        w = pick(req, m_ptr);
        m_owner = w;
        e_grant = 3'(1 << w);
`ifdef ARB_RR_EN
        m_ptr = (w + 1) % 3;
`else
        m_ptr = 0;
`endif
      end
    end else if (!req[m_owner]) begin
      e_grant = 3'b000;
      m_owner = -1;
      m_free = cyc + 1 + LAT;
    end else begin
      i = m_owner;
      e_addr = req_addr[i*AW +: AW];
      e_wd   = req_wdata[i*DW +: DW];
      if (req_w[i]) begin
        e_w = 1'b1;
        shadow[e_addr] = e_wd;
        if (req_r[i]) e_err = 1'b1;
      end else if (req_r[i]) begin
        e_r = 1'b1;
        exp_rv[cyc + 1 + LAT] = exp_rv[cyc + 1 + LAT] | (3'b001 << i);
        exp_rd[cyc + 1 + LAT] = shadow[e_addr];
      end
    end
    cyc++;
    mem_rdata = rsched[cyc];
  endtask

  task automatic check_outputs();
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("mem_r", 32'(mem_r), 32'(e_r));
    check_eq("mem_w", 32'(mem_w), 32'(e_w));
    check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check_eq("err", 32'(err), 32'(e_err));
    check_eq("rvalid", 32'(rvalid), 32'(exp_rv[cyc]));
    if (exp_rv[cyc] != 3'b000) check_eq("rdata", 32'(rdata), 32'(exp_rd[cyc]));
    s_r = mem_r; s_w = mem_w; s_addr = mem_addr; s_wd = mem_wdata;
  endtask

  // Inputs are set at the negedge before calling; outputs checked at the following negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; req = 3'b000; req_r = 3'b000; req_w = 3'b000;
    req_addr = '0; req_wdata = '0;
    for (int k = 0; k < (1 << AW); k++) begin
      sram[k] = '0; shadow[k] = '0;
    end
    sram[10'h080] = 8'hFF; shadow[10'h080] = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    model_reset();

    // Single read by requester 1
    req = 3'b010; cycle();
    req_r = 3'b010; set_cmd(1, 10'h080, 8'h00); cycle();
    req_r = 3'b000; repeat (LAT + 2) cycle();
    req = 3'b000; repeat (LAT + 2) cycle();

    // Write pass-through and readback by requester 2
    req = 3'b100; cycle();
    req_w = 3'b100; set_cmd(2, 10'h100, 8'hA5); cycle();
    req_w = 3'b000; req_r = 3'b100; cycle();
    req_r = 3'b000; repeat (LAT + 2) cycle();
    req = 3'b000; repeat (LAT + 2) cycle();

    // Contention: three ownership rounds with every request raised
`ifdef ARB_RR_EN
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
`else
    order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001;
`endif
    req = 3'b111;
    for (int r = 0; r < 3; r++) begin
      repeat (LAT + 2) cycle();
      check_eq("contend_order", 32'(grant), 32'(order[r]));
      if (m_owner >= 0) req = 3'b111 & ~(3'b001 << m_owner);
      cycle();
      req = 3'b111;
    end
    req = 3'b000; repeat (LAT + 3) cycle();

    // Release with a read in flight, next requester rises in the same cycle
    req = 3'b001; cycle();
    req_r = 3'b001; set_cmd(0, 10'h100, 8'h00); cycle();
    req = 3'b010; req_r = 3'b000; cycle();
    repeat (LAT + 4) cycle();
    req = 3'b000; repeat (LAT + 2) cycle();

    // Read/write conflict sets the sticky error
    req = 3'b001; cycle();
    req_r = 3'b001; req_w = 3'b001; set_cmd(0, 10'h005, 8'h3C); cycle();
    req_r = 3'b000; req_w = 3'b000; repeat (2) cycle();
    req = 3'b000; repeat (LAT + 2) cycle();

    // Random traffic with sticky requests
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        set_cmd(b, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      end
      req_r = 3'($urandom);
      req_w = 3'($urandom) & 3'($urandom) & 3'($urandom);
      cycle();
    end
    req = 3'b000; req_r = 3'b000; req_w = 3'b000;
    repeat (LAT + 3) cycle();

    // Reset with a read in flight
    req = 3'b001; cycle();
    req_r = 3'b001; set_cmd(0, 10'h080, 8'h00); cycle();
    req_r = 3'b000; req = 3'b000;
    rst = 1'b1;
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_mem_r", 32'(mem_r), 32'd0);
    check_eq("rst_mem_w", 32'(mem_w), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (LAT + 4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
